// File: rtl/apb_trigger_router.sv
// apb_trigger_router: APB-programmed crossbar routing trigger inputs to outputs
// with per-output enable/invert/stretch, saturating edge counters and activity LEDs.
module apb_trigger_router #(
    parameter int NUM_INPUTS    = 12,
    parameter int NUM_OUTPUTS   = 14,
    parameter int STRETCH_WIDTH = 16,
    parameter int COUNT_WIDTH   = 32,
    parameter int LED_CYCLES    = 2500000
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [11:0]            paddr,
    input  logic [31:0]            pwdata,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [NUM_INPUTS-1:0]  trig_in,
    output logic [NUM_OUTPUTS-1:0] trig_out,
    output logic [NUM_INPUTS-1:0]  trig_in_led,
    output logic [NUM_OUTPUTS-1:0] trig_out_led
);
    localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam int LW = $clog2(LED_CYCLES + 1);

    logic [IW-1:0]            sel     [NUM_OUTPUTS];
    logic [STRETCH_WIDTH-1:0] stretch [NUM_OUTPUTS];
    logic [STRETCH_WIDTH-1:0] timer   [NUM_OUTPUTS];
    logic [COUNT_WIDTH-1:0]   cnt     [NUM_INPUTS];
    logic [LW-1:0]            in_led  [NUM_INPUTS];
    logic [LW-1:0]            out_led [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0]   en, inv, s, s_prev, s_rise, out_prev, out_rise;
    logic [NUM_INPUTS-1:0]    in_q, prev_q, in_rise;
    logic                     is_cnt, err, wr;
    logic [5:0]               ch;
    logic [2:0]               off;
    logic [8:0]               cidx;
    logic [31:0]              rdata;

    assign is_cnt  = paddr[11];
    assign ch      = paddr[10:5];
    assign off     = paddr[4:2];
    assign cidx    = paddr[10:2];
    assign pready  = psel & penable;
    assign err     = paddr[1:0] != 2'b00 ||
                     (is_cnt ? 32'(cidx) >= NUM_INPUTS :
                      32'(ch) >= NUM_OUTPUTS || off > 3'd2 ||
                      (pwrite && off == 3'd0 && pwdata >= NUM_INPUTS) ||
                      (pwrite && off == 3'd2 && (pwdata >> STRETCH_WIDTH) != 32'd0));
    assign pslverr = pready & err;
    assign wr      = pready & pwrite & ~err;
    assign prdata  = pready && !err ? rdata : 32'd0;

    assign in_rise  = in_q & ~prev_q;
    assign s_rise   = s & ~s_prev;
    assign out_rise = trig_out & ~out_prev;

    always_comb begin
        rdata = 32'd0;
        for (int n = 0; n < NUM_OUTPUTS; n++)
            if (!is_cnt && 32'(ch) == n)
                rdata = off == 3'd0 ? 32'(sel[n]) :
                        off == 3'd1 ? {30'd0, inv[n], en[n]} : 32'(stretch[n]);
        for (int i = 0; i < NUM_INPUTS; i++)
            if (is_cnt && 32'(cidx) == i)
                rdata = 32'(cnt[i]);
    end

    always_comb begin
        s = '0;
        for (int n = 0; n < NUM_OUTPUTS; n++)
            s[n] = in_q[sel[n]] ^ inv[n];
    end

    always_comb begin
        trig_in_led  = '0;
        trig_out_led = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            trig_in_led[i] = in_led[i] != '0;
        for (int n = 0; n < NUM_OUTPUTS; n++)
            trig_out_led[n] = out_led[n] != '0;
    end

    // A clear write landing on an edge leaves the counter at 1, not 0.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            in_q   <= '0;
            prev_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt[i] <= '0;
        end else begin
            in_q   <= trig_in;
            prev_q <= in_q;
            for (int i = 0; i < NUM_INPUTS; i++)
                if (wr && is_cnt && 32'(cidx) == i)
                    cnt[i] <= COUNT_WIDTH'(in_rise[i]);
                else if (in_rise[i] && cnt[i] != '1)
                    cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            en       <= '0;
            inv      <= '0;
            s_prev   <= '0;
            out_prev <= '0;
            trig_out <= '0;
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
                sel[n]     <= '0;
                stretch[n] <= '0;
                timer[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
                if (wr && !is_cnt && 32'(ch) == n) begin
                    if (off == 3'd0)
                        sel[n] <= pwdata[IW-1:0];
                    if (off == 3'd1) begin
                        en[n]  <= pwdata[0];
                        inv[n] <= pwdata[1];
                    end
                    if (off == 3'd2)
                        stretch[n] <= pwdata[STRETCH_WIDTH-1:0];
                end
                s_prev[n]   <= s[n];
                timer[n]    <= !en[n] ? '0 : s_rise[n] ? stretch[n] :
                               timer[n] != '0 ? timer[n] - STRETCH_WIDTH'(1) : '0;
                trig_out[n] <= en[n] & (s[n] | timer[n] != '0);
                out_prev[n] <= trig_out[n];
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_INPUTS; i++)
                in_led[i] <= '0;
            for (int n = 0; n < NUM_OUTPUTS; n++)
                out_led[n] <= '0;
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++)
                in_led[i] <= in_rise[i] ? LW'(LED_CYCLES) :
                             in_led[i] != '0 ? in_led[i] - LW'(1) : '0;
            for (int n = 0; n < NUM_OUTPUTS; n++)
                out_led[n] <= out_rise[n] ? LW'(LED_CYCLES) :
                              out_led[n] != '0 ? out_led[n] - LW'(1) : '0;
        end
    end
endmodule
